// File: rtl/mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : mc_controller
// Description : Moore control FSM with ALU and immediate decoders that
//               sequences the shared datapath of the RV32I multicycle core.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic [1:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic [2:0] alu_control,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_RESET    = 4'd15
    } state_t;

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_RTYPE = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE = 7'b0010011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_BEQ   = 7'b1100011;

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] w_aluop;
    logic       w_branch;
    logic       w_pc_update;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RESET;
        else        r_state <= w_next_state;
    end

    assign state = r_state;

    always_comb begin
        w_next_state = S_FETCH;
        w_aluop      = 2'b00;
        w_branch     = 1'b0;
        w_pc_update  = 1'b0;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        result_src   = 2'b00;
        adr_src      = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        mem_write    = 1'b0;
        illegal_op   = 1'b0;
        case (r_state)
            S_RESET: w_next_state = S_FETCH;
            S_FETCH: begin
                ir_write     = 1'b1;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                w_pc_update  = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target old_pc + imm
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    c_OP_LOAD, c_OP_STORE: w_next_state = S_MEMADR;
                    c_OP_RTYPE:            w_next_state = S_EXECUTER;
                    c_OP_ITYPE:            w_next_state = S_EXECUTEI;
                    c_OP_JAL:              w_next_state = S_JAL;
                    c_OP_BEQ:              w_next_state = S_BEQ;
                    default: begin
                        illegal_op   = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                w_next_state = (op == c_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src      = 1'b1;
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src   = 2'b01;
                reg_write    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src      = 1'b1;
                mem_write    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a    = 2'b10;
                w_aluop      = 2'b10;
                w_next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                w_aluop      = 2'b10;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write    = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JAL: begin
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                w_pc_update  = 1'b1;
                w_next_state = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a    = 2'b10;
                w_aluop      = 2'b01;
                w_branch     = 1'b1;
                w_next_state = S_FETCH;
            end
            default: w_next_state = S_FETCH;
        endcase
    end

    // Branch resolution is combinational on zero so BEQ needs no extra cycle
    assign pc_write = w_pc_update | (w_branch & zero);

    always_comb begin
        case (op)
            c_OP_STORE: imm_src = 2'd1;
            c_OP_BEQ:   imm_src = 2'd2;
            c_OP_JAL:   imm_src = 2'd3;
            default:    imm_src = 2'd0;
        endcase
    end

    always_comb begin
        alu_control = 3'b000;
        case (w_aluop)
            2'b01: alu_control = 3'b001;
            2'b10: begin
                case (funct3)
                    // Subtract only for R-type; I-type has no subi
                    3'b000:  alu_control = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mc_controller
// Description : Directed self-checking bench for mc_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mc_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic [1:0] imm_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       adr_src;
    logic [2:0] alu_control;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       mem_write;
    logic       illegal_op;
    logic [3:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    mc_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .imm_src    (imm_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .adr_src    (adr_src),
        .alu_control(alu_control),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .illegal_op (illegal_op),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [21:0] all_out;
        rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        all_out = {imm_src, alu_src_a, alu_src_b, result_src, adr_src, alu_control,
                   ir_write, pc_write, reg_write, mem_write, illegal_op, 4'd0};
        n_tests++;
        if (state !== 4'd15) begin n_fail++; $display("FAIL reset_state: got %0d want 15", state); end
        n_tests++;
        if (all_out !== 22'd0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (state !== 4'd15 || ir_write !== 1'b0 || pc_write !== 1'b0)
        begin n_fail++; $display("FAIL reset_release: state %0d irw %b pcw %b want 15 0 0", state, ir_write, pc_write); end
        step();
        n_tests++;
        if (state !== 4'd0 || ir_write !== 1'b1 || pc_write !== 1'b1 || alu_src_b !== 2'b10)
        begin n_fail++; $display("FAIL first_fetch: state %0d irw %b pcw %b srcb %b want 0 1 1 10", state, ir_write, pc_write, alu_src_b); end
    endtask

    task automatic test_lw();
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0;
        step();
        n_tests++;
        if (state !== 4'd1 || imm_src !== 2'd0) begin n_fail++; $display("FAIL lw_decode: state %0d imm %0d want 1 0", state, imm_src); end
        step();
        n_tests++;
        if (state !== 4'd2 || alu_src_a !== 2'b10 || alu_src_b !== 2'b01 || alu_control !== 3'b000)
        begin n_fail++; $display("FAIL lw_memadr: state %0d a %b b %b alu %b want 2 10 01 000", state, alu_src_a, alu_src_b, alu_control); end
        step();
        n_tests++;
        if (state !== 4'd3 || adr_src !== 1'b1 || result_src !== 2'b00)
        begin n_fail++; $display("FAIL lw_memread: state %0d adr %b res %b want 3 1 00", state, adr_src, result_src); end
        step();
        n_tests++;
        if (state !== 4'd4 || result_src !== 2'b01 || reg_write !== 1'b1)
        begin n_fail++; $display("FAIL lw_memwb: state %0d res %b rw %b want 4 01 1", state, result_src, reg_write); end
        step();
        n_tests++;
        if (state !== 4'd0) begin n_fail++; $display("FAIL lw_return: got %0d want 0", state); end
    endtask

    task automatic test_sw();
        logic [3:0] exp_seq [4] = '{4'd1, 4'd2, 4'd5, 4'd0};
        op = 7'b0100011; funct3 = 3'b010;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if (state !== exp_seq[i] || imm_src !== 2'd1 || mem_write !== (exp_seq[i] == 4'd5))
            begin n_fail++; $display("FAIL sw_step%0d: state %0d imm %0d mw %b want %0d 1 %b", i, state, imm_src, mem_write, exp_seq[i], exp_seq[i] == 4'd5); end
        end
    endtask

    task automatic test_alu_decode();
        // R-type sub
        op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
        step(); step();
        n_tests++;
        if (state !== 4'd6 || alu_control !== 3'b001 || alu_src_a !== 2'b10 || alu_src_b !== 2'b00)
        begin n_fail++; $display("FAIL rtype_sub: state %0d alu %b a %b b %b want 6 001 10 00", state, alu_control, alu_src_a, alu_src_b); end
        step();
        n_tests++;
        if (state !== 4'd8 || reg_write !== 1'b1 || result_src !== 2'b00)
        begin n_fail++; $display("FAIL rtype_aluwb: state %0d rw %b res %b want 8 1 00", state, reg_write, result_src); end
        step();
        // addi with funct7b5 set must still add
        op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b1;
        step(); step();
        n_tests++;
        if (state !== 4'd7 || alu_control !== 3'b000 || alu_src_b !== 2'b01)
        begin n_fail++; $display("FAIL addi: state %0d alu %b b %b want 7 000 01", state, alu_control, alu_src_b); end
        step(); step();
        // slt
        op = 7'b0110011; funct3 = 3'b010; funct7b5 = 1'b0;
        step(); step();
        n_tests++;
        if (state !== 4'd6 || alu_control !== 3'b101)
        begin n_fail++; $display("FAIL slt: state %0d alu %b want 6 101", state, alu_control); end
        step(); step();
        // ori
        op = 7'b0010011; funct3 = 3'b110;
        step(); step();
        n_tests++;
        if (state !== 4'd7 || alu_control !== 3'b011)
        begin n_fail++; $display("FAIL ori: state %0d alu %b want 7 011", state, alu_control); end
        step(); step();
        // and
        op = 7'b0110011; funct3 = 3'b111;
        step(); step();
        n_tests++;
        if (state !== 4'd6 || alu_control !== 3'b010)
        begin n_fail++; $display("FAIL and: state %0d alu %b want 6 010", state, alu_control); end
        step(); step();
        n_tests++;
        if (state !== 4'd0) begin n_fail++; $display("FAIL alu_return: got %0d want 0", state); end
    endtask

    task automatic test_branch_jump();
        op = 7'b1100011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b1;
        step();
        n_tests++;
        if (state !== 4'd1 || imm_src !== 2'd2 || alu_src_a !== 2'b01 || alu_src_b !== 2'b01)
        begin n_fail++; $display("FAIL beq_decode: state %0d imm %0d a %b b %b want 1 2 01 01", state, imm_src, alu_src_a, alu_src_b); end
        step();
        n_tests++;
        if (state !== 4'd9 || pc_write !== 1'b1 || alu_control !== 3'b001)
        begin n_fail++; $display("FAIL beq_taken: state %0d pcw %b alu %b want 9 1 001", state, pc_write, alu_control); end
        zero = 1'b0;
        #1;
        n_tests++;
        if (pc_write !== 1'b0) begin n_fail++; $display("FAIL beq_not_taken: pcw %b want 0", pc_write); end
        step();
        n_tests++;
        if (state !== 4'd0) begin n_fail++; $display("FAIL beq_return: got %0d want 0", state); end
        op = 7'b1101111;
        step();
        n_tests++;
        if (state !== 4'd1 || imm_src !== 2'd3) begin n_fail++; $display("FAIL jal_decode: state %0d imm %0d want 1 3", state, imm_src); end
        step();
        n_tests++;
        if (state !== 4'd10 || pc_write !== 1'b1 || alu_src_a !== 2'b01 || alu_src_b !== 2'b10)
        begin n_fail++; $display("FAIL jal_state: state %0d pcw %b a %b b %b want 10 1 01 10", state, pc_write, alu_src_a, alu_src_b); end
        step();
        n_tests++;
        if (state !== 4'd8 || reg_write !== 1'b1 || pc_write !== 1'b0)
        begin n_fail++; $display("FAIL jal_aluwb: state %0d rw %b pcw %b want 8 1 0", state, reg_write, pc_write); end
        step();
        n_tests++;
        if (state !== 4'd0) begin n_fail++; $display("FAIL jal_return: got %0d want 0", state); end
    endtask

    task automatic test_illegal_and_abort();
        op = 7'b0000000;
        step();
        n_tests++;
        if (state !== 4'd1 || illegal_op !== 1'b1 || reg_write !== 1'b0 || mem_write !== 1'b0)
        begin n_fail++; $display("FAIL illegal_decode: state %0d ill %b rw %b mw %b want 1 1 0 0", state, illegal_op, reg_write, mem_write); end
        step();
        n_tests++;
        if (state !== 4'd0 || illegal_op !== 1'b0) begin n_fail++; $display("FAIL illegal_return: state %0d ill %b want 0 0", state, illegal_op); end
        op = 7'b0100011;
        step(); step(); step();
        n_tests++;
        if (state !== 4'd5 || mem_write !== 1'b1) begin n_fail++; $display("FAIL abort_pre: state %0d mw %b want 5 1", state, mem_write); end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (state !== 4'd15 || mem_write !== 1'b0 || adr_src !== 1'b0)
        begin n_fail++; $display("FAIL abort_reset: state %0d mw %b adr %b want 15 0 0", state, mem_write, adr_src); end
        step();
        rst_n = 1'b1;
        step();
        n_tests++;
        if (state !== 4'd0 || ir_write !== 1'b1) begin n_fail++; $display("FAIL abort_refetch: state %0d irw %b want 0 1", state, ir_write); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_alu_decode();
        test_branch_jump();
        test_illegal_and_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
